// File: rtl/aes_axis_block_packer.sv
// Packs a DATA_W-bit AXI-Stream into mode-tagged 128-bit AES blocks queued in a DEPTH-entry FIFO.
// Optional AES_PKT_PAD_EN: a short packet is zero-padded into a block instead of being dropped.
module aes_axis_block_packer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                    axis_aclk,
  input  logic                    axis_aresetn,
  input  logic                    clear_i,
  input  logic [1:0]              mode_i,
  input  logic [DATA_W-1:0]       s_axis_tdata,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic [127:0]            m_blk_data,
  output logic [1:0]              m_blk_mode,
  output logic                    m_blk_last,
  output logic                    m_blk_pad,
  output logic                    m_blk_valid,
  input  logic                    m_blk_ready,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic                    err_o
);

  localparam int unsigned WORDS = 128 / DATA_W;
  localparam int unsigned CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
`ifdef AES_PKT_PAD_EN
  localparam int unsigned ENT_W = 132;
`else
  localparam int unsigned ENT_W = 131;
`endif

  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic [127:0]     asm_q, blk_c;
  logic [1:0]       mode_q, blk_mode_c;
  logic             err_q, err_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] entry_c, head_c;
  logic             last_word_c, full_c, xfer_c, push_c, drop_c, pop_c;

  assign last_word_c = (wcnt_q == CNT_W'(WORDS - 1));
  assign full_c      = (level_q == LVL_W'(DEPTH));
  assign xfer_c      = s_axis_tvalid && s_axis_tready;
  assign pop_c       = m_blk_valid && m_blk_ready;

`ifdef AES_PKT_PAD_EN
  assign s_axis_tready = !(full_c && (last_word_c || s_axis_tlast));
  assign push_c        = xfer_c && (last_word_c || s_axis_tlast);
  assign drop_c        = 1'b0;
  assign entry_c       = {!last_word_c, blk_mode_c, s_axis_tlast, blk_c};
`else
  assign s_axis_tready = !(full_c && last_word_c);
  assign push_c        = xfer_c && last_word_c;
  assign drop_c        = xfer_c && s_axis_tlast && !last_word_c;
  assign entry_c       = {blk_mode_c, s_axis_tlast, blk_c};
`endif

  // Block as it would look with the current word merged; a new block starts from zeros
  always_comb begin
    blk_c      = (wcnt_q == '0) ? '0 : asm_q;
    blk_mode_c = (wcnt_q == '0) ? mode_i : mode_q;
    for (int unsigned k = 0; k < WORDS; k++) begin
      if (wcnt_q == CNT_W'(k)) blk_c[127 - k*DATA_W -: DATA_W] = s_axis_tdata;
    end
  end

  always_comb begin
    wcnt_d   = wcnt_q;
    err_d    = err_q;
    level_d  = level_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear_i) begin
      wcnt_d   = '0;
      err_d    = 1'b0;
      level_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (xfer_c) wcnt_d = (push_c || drop_c) ? '0 : wcnt_q + CNT_W'(1);
      if (drop_c) err_d = 1'b1;
      if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      wcnt_q   <= '0;
      asm_q    <= '0;
      mode_q   <= '0;
      err_q    <= 1'b0;
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wcnt_q   <= wcnt_d;
      err_q    <= err_d;
      level_q  <= level_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (xfer_c && !clear_i) begin
        asm_q  <= blk_c;
        mode_q <= blk_mode_c;
      end
    end
  end

  // Block storage; cleared on reset so the idle head reads as zero
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_c && !clear_i) begin
      mem_q[wr_ptr_q] <= entry_c;
    end
  end

  assign head_c      = mem_q[rd_ptr_q];
  assign m_blk_data  = head_c[127:0];
  assign m_blk_last  = head_c[128];
  assign m_blk_mode  = head_c[130:129];
  assign m_blk_valid = (level_q != '0);
  assign level_o     = level_q;
  assign err_o       = err_q;
`ifdef AES_PKT_PAD_EN
  assign m_blk_pad   = head_c[131];
`else
  assign m_blk_pad   = 1'b0;
`endif

endmodule

// File: tb/tb_aes_axis_block_packer.sv
// Randomized self-checking bench for aes_axis_block_packer (default build, DEPTH=4, DATA_W=32 and 64).
module tb_aes_axis_block_packer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         clear = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [31:0]  tdata = '0;
  logic         tvalid = 1'b0, tlast = 1'b0, tready;
  logic [127:0] bdata;
  logic [1:0]   bmode;
  logic         blast, bpad, bvalid;
  logic         bready = 1'b0;
  logic [2:0]   level;
  logic         err;

  aes_axis_block_packer #(.DATA_W(32), .DEPTH(4)) u_dut (
    .axis_aclk(clk), .axis_aresetn(rst_n), .clear_i(clear), .mode_i(mode),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast), .s_axis_tready(tready),
    .m_blk_data(bdata), .m_blk_mode(bmode), .m_blk_last(blast), .m_blk_pad(bpad),
    .m_blk_valid(bvalid), .m_blk_ready(bready), .level_o(level), .err_o(err)
  );

  logic         clear64 = 1'b0;
  logic [1:0]   mode64 = 2'b00;
  logic [63:0]  tdata64 = '0;
  logic         tvalid64 = 1'b0, tlast64 = 1'b0, tready64;
  logic [127:0] bdata64;
  logic [1:0]   bmode64;
  logic         blast64, bpad64, bvalid64;
  logic         bready64 = 1'b0;
  logic [2:0]   level64;
  logic         err64;

  aes_axis_block_packer #(.DATA_W(64), .DEPTH(4)) u_dut64 (
    .axis_aclk(clk), .axis_aresetn(rst_n), .clear_i(clear64), .mode_i(mode64),
    .s_axis_tdata(tdata64), .s_axis_tvalid(tvalid64), .s_axis_tlast(tlast64), .s_axis_tready(tready64),
    .m_blk_data(bdata64), .m_blk_mode(bmode64), .m_blk_last(blast64), .m_blk_pad(bpad64),
    .m_blk_valid(bvalid64), .m_blk_ready(bready64), .level_o(level64), .err_o(err64)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: word-level packing into a queue of {mode, last, data}
  logic [127:0] m_acc;
  logic [1:0]   m_mode;
  int           m_cnt;
  bit           m_err;
  logic [130:0] exp_q[$];

  task automatic model_reset;
    exp_q.delete();
    m_cnt  = 0;
    m_err  = 1'b0;
    m_acc  = '0;
    m_mode = '0;
  endtask

  task automatic model_word(input logic [31:0] w, input bit l, input logic [1:0] md);
    if (m_cnt == 0) begin
      m_acc  = '0;
      m_mode = md;
    end
    m_acc = m_acc | (128'(w) << (96 - 32 * m_cnt));
    if (m_cnt == 3) begin
      exp_q.push_back({m_mode, l, m_acc});
      m_cnt = 0;
    end else if (l) begin
      m_err = 1'b1;
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
  endtask

  // One clock: records handshakes seen before the edge, advances the model
  task automatic step(output bit x, output bit p, output logic [130:0] got, output logic [130:0] expv);
    bit          pre_clr;
    logic [31:0] w;
    bit          l;
    logic [1:0]  md;
    x       = tvalid && tready;
    p       = bvalid && bready;
    got     = {bmode, blast, bdata};
    expv    = 'x;
    pre_clr = clear;
    w = tdata; l = tlast; md = mode;
    @(posedge clk); #1;
    if (pre_clr) begin
      model_reset();
      x = 1'b0;
      p = 1'b0;
    end else begin
      if (p && exp_q.size() > 0) expv = exp_q.pop_front();
      if (x) model_word(w, l, md);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; tvalid = 1'b1; tdata = 32'hFFFF_FFFF; tlast = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (tready !== 1'b1) $display("FAIL reset_tready got=%b want=1", tready); else n_pass++;
    n_chk++; if (bvalid !== 1'b0) $display("FAIL reset_valid got=%b want=0", bvalid); else n_pass++;
    n_chk++; if (bdata !== 128'h0) $display("FAIL reset_data got=%h want=0", bdata); else n_pass++;
    n_chk++; if ({bmode, blast, bpad} !== 4'b0) $display("FAIL reset_tags got=%b want=0000", {bmode, blast, bpad}); else n_pass++;
    n_chk++; if ({level, err} !== 4'b0) $display("FAIL reset_level_err got=%b want=0000", {level, err}); else n_pass++;
    tvalid = 1'b0; tlast = 1'b0;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    n_chk++; if ({bvalid, level} !== 4'b0) $display("FAIL reset_ignored got=%b want=0000", {bvalid, level}); else n_pass++;
  endtask

  task automatic test_basic;
    logic [31:0] w4 [4] = '{32'h0011_2233, 32'h4455_6677, 32'h8899_AABB, 32'hCCDD_EEFF};
    bit x, p;
    logic [130:0] got, expv;
    bready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tvalid = 1'b1; tdata = w4[i]; tlast = (i == 3);
      mode = (i == 0) ? 2'b01 : 2'b10;
      step(x, p, got, expv);
    end
    tvalid = 1'b0; tlast = 1'b0;
    n_chk++; if (bvalid !== 1'b1) $display("FAIL basic_valid got=%b want=1", bvalid); else n_pass++;
    n_chk++; if (bdata !== 128'h00112233445566778899AABBCCDDEEFF) $display("FAIL basic_data got=%h want=00112233445566778899aabbccddeeff", bdata); else n_pass++;
    n_chk++; if ({bmode, blast, bpad} !== 4'b0110) $display("FAIL basic_tags got=%b want=0110", {bmode, blast, bpad}); else n_pass++;
    n_chk++; if (level !== 3'd1) $display("FAIL basic_level got=%0d want=1", level); else n_pass++;
    bready = 1'b1;
    step(x, p, got, expv);
    bready = 1'b0;
    n_chk++; if (!p || got !== expv) $display("FAIL basic_pop got=%h want=%h", got, expv); else n_pass++;
    n_chk++; if ({bvalid, level} !== 4'b0) $display("FAIL basic_empty got=%b want=0000", {bvalid, level}); else n_pass++;
  endtask

  task automatic test_backpressure;
    bit x, p;
    logic [130:0] got, expv;
    int popped = 0;
    bready = 1'b0;
    for (int i = 0; i < 19; i++) begin
      tvalid = 1'b1; tdata = $urandom;
      tlast = (i % 4 == 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      mode = 2'($urandom_range(0, 2));
      n_chk++; if (tready !== 1'b1) $display("FAIL bp_ready_word%0d got=%b want=1", i + 1, tready); else n_pass++;
      step(x, p, got, expv);
      if (i == 15) begin
        n_chk++; if (level !== 3'd4) $display("FAIL bp_level_full got=%0d want=4", level); else n_pass++;
      end
    end
    tdata = $urandom; tlast = 1'b1; mode = 2'($urandom_range(0, 2));
    for (int c = 0; c < 3; c++) begin
      n_chk++; if (tready !== 1'b0) $display("FAIL bp_stall%0d got=%b want=0", c, tready); else n_pass++;
      step(x, p, got, expv);
    end
    bready = 1'b1;
    step(x, p, got, expv);
    n_chk++; if (tready !== 1'b1) $display("FAIL bp_ready_restore got=%b want=1", tready); else n_pass++;
    if (p) begin
      popped++;
      n_chk++; if (got !== expv) $display("FAIL bp_pop%0d got=%h want=%h", popped, got, expv); else n_pass++;
    end
    for (int c = 0; c < 40 && popped < 5; c++) begin
      step(x, p, got, expv);
      if (x) begin tvalid = 1'b0; tlast = 1'b0; end
      if (p) begin
        popped++;
        n_chk++; if (got !== expv) $display("FAIL bp_pop%0d got=%h want=%h", popped, got, expv); else n_pass++;
      end
    end
    tvalid = 1'b0; tlast = 1'b0; bready = 1'b0;
    n_chk++; if (popped != 5 || level !== 3'd0) $display("FAIL bp_count got=%0d/%0d want=5/0", popped, level); else n_pass++;
  endtask

  task automatic test_push_pop;
    bit x, p;
    logic [130:0] got, expv;
    bit exp_rdy;
    bready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tvalid = 1'b1; tdata = $urandom;
      tlast = (i % 4 == 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      mode = 2'($urandom_range(0, 2));
      step(x, p, got, expv);
    end
    n_chk++; if (level !== 3'd3) $display("FAIL pp_fill got=%0d want=3", level); else n_pass++;
    for (int c = 0; c < 24; c++) begin
      tdata = $urandom; mode = 2'($urandom_range(0, 2));
      tlast = (m_cnt == 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      bready = (m_cnt == 3);
      step(x, p, got, expv);
      if (p) begin
        n_chk++; if (got !== expv) $display("FAIL pp_const_pop c=%0d got=%h want=%h", c, got, expv); else n_pass++;
      end
      n_chk++; if (level !== 3'd3) $display("FAIL pp_const_level c=%0d got=%0d want=3", c, level); else n_pass++;
    end
    for (int c = 0; c < 80; c++) begin
      tvalid = 1'($urandom_range(0, 1)); tdata = $urandom; mode = 2'($urandom_range(0, 2));
      tlast = (m_cnt == 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      bready = 1'($urandom_range(0, 1));
      exp_rdy = !(m_cnt == 3 && exp_q.size() == 4);
      n_chk++; if (tready !== exp_rdy) $display("FAIL pp_rand_ready c=%0d got=%b want=%b", c, tready, exp_rdy); else n_pass++;
      step(x, p, got, expv);
      if (p) begin
        n_chk++; if (got !== expv) $display("FAIL pp_rand_pop c=%0d got=%h want=%h", c, got, expv); else n_pass++;
      end
      n_chk++; if (level !== 3'(exp_q.size())) $display("FAIL pp_rand_level c=%0d got=%0d want=%0d", c, level, exp_q.size()); else n_pass++;
    end
    tvalid = 1'b0; tlast = 1'b0; bready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      step(x, p, got, expv);
      if (p) begin
        n_chk++; if (got !== expv) $display("FAIL pp_drain_pop got=%h want=%h", got, expv); else n_pass++;
      end
    end
    bready = 1'b0;
    n_chk++; if (bvalid !== 1'b0) $display("FAIL pp_drained got=%b want=0", bvalid); else n_pass++;
    clear = 1'b1;
    step(x, p, got, expv);
    clear = 1'b0;
  endtask

  task automatic test_drop;
    bit x, p;
    logic [130:0] got, expv;
    bready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tvalid = 1'b1; tdata = 32'hA + 32'(i); tlast = (i == 2); mode = 2'b00;
      step(x, p, got, expv);
    end
    tvalid = 1'b0; tlast = 1'b0;
    n_chk++; if (err !== m_err || err !== 1'b1) $display("FAIL drop_err got=%b want=1", err); else n_pass++;
    n_chk++; if ({bvalid, level} !== 4'b0) $display("FAIL drop_noblock got=%b want=0000", {bvalid, level}); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      tvalid = 1'b1; tdata = 32'(i + 1); tlast = (i == 3); mode = (i == 0) ? 2'b10 : 2'b01;
      step(x, p, got, expv);
    end
    tvalid = 1'b0; tlast = 1'b0;
    n_chk++; if (bdata !== 128'h00000001_00000002_00000003_00000004) $display("FAIL drop_next_data got=%h want=00000001000000020000000300000004", bdata); else n_pass++;
    n_chk++; if ({bmode, err} !== 3'b101) $display("FAIL drop_next_mode_err got=%b want=101", {bmode, err}); else n_pass++;
    bready = 1'b1;
    step(x, p, got, expv);
    bready = 1'b0;
    n_chk++; if (!p || got !== expv) $display("FAIL drop_pop got=%h want=%h", got, expv); else n_pass++;
  endtask

  task automatic test_clear;
    bit x, p;
    logic [130:0] got, expv;
    bready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tvalid = 1'b1; tdata = $urandom; tlast = (i == 3); mode = 2'($urandom_range(0, 2));
      if (i == 7) clear = 1'b1;
      step(x, p, got, expv);
    end
    clear = 1'b0; tvalid = 1'b0; tlast = 1'b0;
    n_chk++; if ({bvalid, level, err} !== 5'b0) $display("FAIL clear_state got=%b want=00000", {bvalid, level, err}); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      tvalid = 1'b1; tdata = 32'hC0DE_0000 + 32'(i); tlast = (i == 3); mode = 2'b01;
      step(x, p, got, expv);
    end
    tvalid = 1'b0; tlast = 1'b0;
    n_chk++; if (bdata !== 128'hC0DE0000_C0DE0001_C0DE0002_C0DE0003 || level !== 3'd1) $display("FAIL clear_fresh got=%h/%0d want=c0de0000c0de0001c0de0002c0de0003/1", bdata, level); else n_pass++;
    bready = 1'b1;
    step(x, p, got, expv);
    bready = 1'b0;
    n_chk++; if (!p || got !== expv) $display("FAIL clear_pop got=%h want=%h", got, expv); else n_pass++;
  endtask

  task automatic test_reset_mid;
    bit x, p;
    logic [130:0] got, expv;
    bready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tvalid = 1'b1; tdata = $urandom; tlast = (i == 3 || i == 7); mode = 2'($urandom_range(0, 2));
      step(x, p, got, expv);
    end
    tvalid = 1'b0; tlast = 1'b0;
    n_chk++; if (level !== 3'd2) $display("FAIL rmid_queued got=%0d want=2", level); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++; if ({tready, bvalid, level, err} !== 6'b100000) $display("FAIL rmid_state got=%b want=100000", {tready, bvalid, level, err}); else n_pass++;
    n_chk++; if ({bdata, bmode, blast, bpad} !== 132'h0) $display("FAIL rmid_head got=%h want=0", {bdata, bmode, blast, bpad}); else n_pass++;
    tvalid = 1'b1; tdata = $urandom; tlast = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tvalid = 1'b0; tlast = 1'b0;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      tvalid = 1'b1; tdata = 32'hDEAD_0001 + 32'(i); tlast = (i == 3); mode = 2'b00;
      step(x, p, got, expv);
    end
    tvalid = 1'b0; tlast = 1'b0;
    n_chk++; if (bdata !== 128'hDEAD0001_DEAD0002_DEAD0003_DEAD0004 || level !== 3'd1) $display("FAIL rmid_fresh got=%h/%0d want=dead0001dead0002dead0003dead0004/1", bdata, level); else n_pass++;
  endtask

  task automatic test_w64;
    tvalid64 = 1'b1; tdata64 = 64'h0123_4567_89AB_CDEF; tlast64 = 1'b0; mode64 = 2'b00;
    @(posedge clk); #1;
    n_chk++; if ({bvalid64, level64} !== 4'b0) $display("FAIL w64_partial got=%b want=0000", {bvalid64, level64}); else n_pass++;
    tdata64 = 64'hFEDC_BA98_7654_3210; tlast64 = 1'b1; mode64 = 2'b10;
    @(posedge clk); #1;
    tvalid64 = 1'b0; tlast64 = 1'b0;
    n_chk++; if (bdata64 !== 128'h0123456789ABCDEFFEDCBA9876543210) $display("FAIL w64_data got=%h want=0123456789abcdeffedcba9876543210", bdata64); else n_pass++;
    n_chk++; if ({bvalid64, bmode64, blast64, level64} !== 7'b1001001) $display("FAIL w64_tags got=%b want=1001001", {bvalid64, bmode64, blast64, level64}); else n_pass++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_backpressure();
    test_push_pop();
    test_drop();
    test_clear();
    test_reset_mid();
    test_w64();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/aes_axis_block_packer.md
# aes_axis_block_packer

Parametrised AXI-Stream front end for the AES core. It accepts a narrow input stream of DATA_W-bit words and packs them MSB-first into 128-bit AES blocks. Each block is tagged with the operation mode (encrypt, decrypt, expand key) and queued in a DEPTH-entry block FIFO. The AES datapath consumes blocks through a valid/ready block port.

## Interface
Parameters:
- DATA_W, 32, input word width; legal values are 32, 64, 128; WORDS = 128/DATA_W
- DEPTH, 4, FIFO depth in blocks; power of two, at least 2

Ports:
- axis_aclk  in  1  the single clock
- axis_aresetn  in  1  asynchronous, active-low reset
- clear_i  in  1  synchronous clear: empties the FIFO, drops any partial block, clears err_o
- mode_i  in  2  operation tag: 00 encrypt, 01 decrypt, 10 expand key; sampled with the first word of each block
- s_axis_tdata  in  DATA_W  input word
- s_axis_tvalid  in  1  input word valid
- s_axis_tlast  in  1  end of packet
- s_axis_tready  out  1  input ready
- m_blk_data  out  128  head block
- m_blk_mode  out  2  mode tag of the head block
- m_blk_last  out  1  head block closed a packet
- m_blk_pad  out  1  head block was zero-padded
- m_blk_valid  out  1  FIFO is not empty
- m_blk_ready  in  1  consumer ready
- level_o  out  $clog2(DEPTH)+1  number of blocks in the FIFO
- err_o  out  1  sticky error: a packet ended on a partial block (pad disabled)

## Operation
- A word transfers when s_axis_tvalid and s_axis_tready are both high on a rising edge.
- Word counter wcnt runs 0..WORDS-1. Word k is written into bits [127-k*DATA_W -: DATA_W].
- At wcnt==0, mode_i is latched into the assembly register; it is ignored for the rest of the block.
- A block completes when the word at wcnt==WORDS-1 transfers. The block is pushed to the FIFO with last equal to that word's tlast and pad=0, and wcnt returns to 0.
- s_axis_tready is 0 only when wcnt==WORDS-1 and the FIFO is full. Non-final words are accepted while the FIFO is full.
- s_axis_tready is derived from registered state only. It has no combinational path from m_blk_ready.
- The block port uses standard valid/ready. m_blk_* holds stable while m_blk_valid is high and m_blk_ready is low. A pop occurs when both are high.
- Push and pop in the same cycle: level_o is unchanged and no data is lost. Push while full is impossible because s_axis_tready is low.
- FIFO pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. Full and empty are decided from level_o.
- With DATA_W=128 each transfer is a full block and wcnt is constant 0.
- clear_i has priority over a push or pop in the same cycle. The next cycle shows level_o=0, wcnt=0, err_o=0.

## Timing
- Reset values: s_axis_tready=1, m_blk_valid=0, m_blk_data=0, m_blk_mode=0, m_blk_last=0, m_blk_pad=0, level_o=0, err_o=0.
- Transfers presented while axis_aresetn is low are ignored.
- Latency: when the final word transfers at edge N, m_blk_valid is high from edge N onward if the FIFO was empty. There is one cycle of latency from the last word to block visibility.
- Pop at edge N: the next head is presented from edge N, or m_blk_valid falls at edge N if the FIFO is now empty.
- Reset asserted mid-block or mid-stall: all state is cleared asynchronously and the partial block is discarded.
- Sustained throughput: one word per cycle while the consumer keeps up.

## Configuration
- AES_PKT_PAD_EN defined: tlast on a word with wcnt<WORDS-1 completes the block.
  - Remaining bits are filled with zeros.
  - The block is pushed with last=1, pad=1.
  - That word sees the same tready rule as a final word (blocked when full).
  - err_o stays 0.
- AES_PKT_PAD_EN undefined: tlast on a word with wcnt<WORDS-1 drops the partial block.
  - wcnt returns to 0 and err_o is set (sticky until clear_i or reset).
  - Nothing is pushed.
  - m_blk_pad is tied to 0.

## Test plan
- Reset, DATA_W=32. Send 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF (tlast on the 4th) with mode_i=01 -> one cycle later m_blk_data=0x00112233445566778899AABBCCDDEEFF, m_blk_mode=01, m_blk_last=1, m_blk_pad=0, level_o=1.
- DEPTH=4, m_blk_ready=0, stream 20 words -> level_o=4 after 16 words; tready stays 1 for words 17-19 and drops at word 20. Raising m_blk_ready restores tready next cycle and yields 5 blocks in order.
- Full FIFO with m_blk_ready=1 and continuous input -> simultaneous push/pop keeps level_o constant with no dropped or duplicated blocks (scoreboard).
- 3 words 0xA, 0xB, 0xC with tlast on 0xC:
  - with AES_PKT_PAD_EN -> block 0x0000000A_0000000B_0000000C_00000000, pad=1, last=1.
  - without AES_PKT_PAD_EN -> no block, err_o=1, next 4 words form a correct block.
- DATA_W=64, two words 0x0123456789ABCDEF, 0xFEDCBA9876543210 -> block 0x0123456789ABCDEFFEDCBA9876543210. Change mode_i to 10 after the first word -> m_blk_mode keeps the first-word value.
- Assert axis_aresetn low after 2 of 4 words with 2 blocks queued -> outputs return to reset values immediately. After release, a fresh 4-word block is packed from word 0.
